// File: rtl/ripple_cap_pkg.sv
// Shared types and constants for the ripple counter capture block.
package ripple_cap_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } trk_state_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff_chain.sv
// Per-bit multi-flop synchroniser with synchronous reset.
// Each bit gets its own independent flop chain.
module sync_ff_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
      chain_d = {chain_q[STAGES-2:0], d[gi]};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        chain_q <= '0;
      end else begin
        chain_q <= chain_d;
      end
    end

    assign q[gi] = chain_q[STAGES-1];
  end

endmodule

// File: rtl/ripple_count_capture.sv
// Carries an asynchronous ripple counter into the clk domain, extends it to EXT_W
// bits and offers snapshots over valid/ready. Optional macro: STEP_CHECK_EN.
module ripple_count_capture
  import ripple_cap_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int EXT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_STEP    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] q_async,
  output logic [EXT_W-1:0] ext_count,
  output logic             wrap,
  input  logic             snap_req,
  output logic [EXT_W-1:0] snap_data,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic             snap_ovr,
  output logic             step_err
);

  if (SYNC_STAGES < MIN_SYNC_STAGES || EXT_W <= CNT_W || MAX_STEP < 1) begin : g_param_check
    $error("ripple_count_capture: illegal parameter combination");
  end

  logic [CNT_W-1:0] s_cur;
  logic [CNT_W-1:0] s_prev_q;
  logic [CNT_W-1:0] s_prev_d;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_d;
  logic [CNT_W-1:0] delta;
  logic [EXT_W-1:0] ext_count_q;
  logic [EXT_W-1:0] ext_count_d;
  logic [EXT_W-1:0] snap_data_q;
  logic [EXT_W-1:0] snap_data_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             snap_ovr_q;
  logic             snap_ovr_d;
  logic             stable;
  logic             accept;

  trk_state_t trk_state_q;
  trk_state_t trk_state_d;
  out_state_t out_state_q;
  out_state_t out_state_d;

  sync_ff_chain #(
    .WIDTH  (CNT_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (q_async),
    .q   (s_cur)
  );

  // A value is trusted only once it has been seen on two consecutive cycles,
  // so ripple transients shorter than a clock never reach the accumulator.
  always_comb begin
    s_prev_d = s_cur;
  end

  assign stable = (s_cur == s_prev_q);
  assign delta  = s_cur - acc_q;
  assign accept = (trk_state_q == TRACK) && stable && (s_cur != acc_q);

  // Tracking FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_state_q <= INIT;
    end else begin
      trk_state_q <= trk_state_d;
    end
  end

  // Tracking FSM: next state
  always_comb begin
    trk_state_d = trk_state_q;
    case (trk_state_q)
      INIT:    if (stable) trk_state_d = TRACK;
      TRACK:   trk_state_d = TRACK;
      default: trk_state_d = INIT;
    endcase
  end

  // Tracking FSM: accumulator and wrap detection
  always_comb begin
    acc_d       = acc_q;
    ext_count_d = ext_count_q;
    wrap_d      = 1'b0;
    case (trk_state_q)
      INIT: begin
        if (stable) begin
          acc_d       = s_cur;
          ext_count_d = {{(EXT_W-CNT_W){1'b0}}, s_cur};
        end
      end
      TRACK: begin
        if (accept) begin
          acc_d       = s_cur;
          ext_count_d = ext_count_q + {{(EXT_W-CNT_W){1'b0}}, delta};
          wrap_d      = (s_cur < acc_q);
        end
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Output FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state_q <= EMPTY;
    end else begin
      out_state_q <= out_state_d;
    end
  end

  // Output FSM: next state; a request while draining keeps the slot full
  always_comb begin
    out_state_d = out_state_q;
    case (out_state_q)
      EMPTY:   if (snap_req) out_state_d = FULL;
      FULL:    if (snap_ready && !snap_req) out_state_d = EMPTY;
      default: out_state_d = EMPTY;
    endcase
  end

  // Output FSM: capture uses ext_count_d so the current cycle's update is included
  always_comb begin
    snap_data_d = snap_data_q;
    snap_ovr_d  = snap_ovr_q;
    case (out_state_q)
      EMPTY: begin
        if (snap_req) snap_data_d = ext_count_d;
      end
      FULL: begin
        if (snap_ready) begin
          if (snap_req) snap_data_d = ext_count_d;
        end else if (snap_req) begin
          snap_ovr_d = 1'b1;
        end
      end
      default: begin
        snap_ovr_d = snap_ovr_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q    <= '0;
      acc_q       <= '0;
      ext_count_q <= '0;
      wrap_q      <= 1'b0;
      snap_data_q <= '0;
      snap_ovr_q  <= 1'b0;
    end else begin
      s_prev_q    <= s_prev_d;
      acc_q       <= acc_d;
      ext_count_q <= ext_count_d;
      wrap_q      <= wrap_d;
      snap_data_q <= snap_data_d;
      snap_ovr_q  <= snap_ovr_d;
    end
  end

`ifdef STEP_CHECK_EN
  localparam logic [CNT_W:0] STEP_LIMIT = (CNT_W+1)'(MAX_STEP);

  logic step_err_q;
  logic step_err_d;

  // The full delta is still accumulated; the flag only reports the violation.
  always_comb begin
    step_err_d = step_err_q;
    if (accept && ({1'b0, delta} > STEP_LIMIT)) step_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_err_q <= 1'b0;
    end else begin
      step_err_q <= step_err_d;
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

  assign ext_count  = ext_count_q;
  assign wrap       = wrap_q;
  assign snap_data  = snap_data_q;
  assign snap_valid = (out_state_q == FULL);
  assign snap_ovr   = snap_ovr_q;

endmodule
